instr_seq: RTL and testbench

Multi-cycle instruction sequencer for the 8-bit core. It fetches one 8-bit instruction per pass from the memory port using a req/ready handshake, then decodes the 4-bit opcode and 4-bit operand. It steps the ALU, register file and memory through one fully synchronous state machine, with single-cycle enable strobes in place of derived clocks. It sits between the memory interface, the ALU and the register file.

---
 rtl/instr_seq_pkg.sv | 31 +++
 rtl/instr_seq_wait_timer.sv | 53 +++++
 rtl/instr_seq.sv | 193 +++++++++++++++++++
 tb/tb_instr_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
// Shared definitions for the instruction sequencer: opcode class constants,
// the bit that marks an ALU-class instruction, the sequencer state encoding
// and a small decode helper.
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  // Upper-nibble opcodes for the non-ALU instruction classes.
  localparam logic [3:0] OP_LD    = 4'h8;
  localparam logic [3:0] OP_ST    = 4'h9;
  localparam logic [3:0] OP_MOV16 = 4'hA;
  localparam logic [3:0] OP_HLT   = 4'hF;

  // instr[ALU_CLASS_BIT] == 0 marks an ALU instruction.
  localparam int ALU_CLASS_BIT = 7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMW   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic is_alu(input logic [7:0] ins);
    return (ins[ALU_CLASS_BIT] == 1'b0);
  endfunction

endpackage

// File: rtl/instr_seq_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// 8-bit wait-cycle counter for memory requests. It counts cycles in which
// 'en' is high and is zeroed by 'clear'. 'expired' is raised in the wait cycle
// that brings the count to WAIT_MAX, so the owner can leave the state on that
// same clock edge.
//
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   clear    in  zero the counter (state entry)
//   en       in  count this cycle (request pending, memory not ready)
//   expired  out this wait cycle is the WAIT_MAX-th
// -----------------------------------------------------------------------------
module wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(WAIT_MAX - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (en) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q >= LAST_COUNT);

endmodule

// File: rtl/instr_seq.sv
// -----------------------------------------------------------------------------
// instr_seq
// Multi-cycle sequencer for the 8-bit core. Fetches one instruction through a
// req/ready memory port, decodes it and drives single-cycle enable strobes to
// the ALU, register file and memory from one synchronous state machine.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_rdata/mem_ready memory read data and request-complete
//   mem_req/mem_we      memory request and write qualifier (registered)
//   pc_inc              advance-PC pulse in the accepting fetch cycle
//   instr               latched instruction
//   alu_op/alu_shamt    ALU controls, alu_en execute strobe
//   reg_sel/reg_we      register select and write strobe, reg_wsrc source
//   reg16_src/dst/we    16-bit pair copy controls
//   halted/fault        stopped (HLT or timeout) / memory timeout
// -----------------------------------------------------------------------------
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_inc,
  output logic [7:0] instr,
  output logic [2:0] alu_op,
  output logic [2:0] alu_shamt,
  output logic       alu_en,
  output logic [3:0] reg_sel,
  output logic       reg_we,
  output logic       reg_wsrc,
  output logic [1:0] reg16_src,
  output logic [1:0] reg16_dst,
  output logic       reg16_we,
  output logic       halted,
  output logic       fault
);

  state_t     state_q,    state_d;
  logic [7:0] instr_q,    instr_d;
  logic       mem_req_q,  mem_req_d;
  logic       mem_we_q,   mem_we_d;
  logic       alu_en_q,   alu_en_d;
  logic       reg_we_q,   reg_we_d;
  logic       reg_wsrc_q, reg_wsrc_d;
  logic       reg16_we_q, reg16_we_d;
  logic       halted_q,   halted_d;
  logic       fault_q,    fault_d;

  logic       accept_s;
  logic       wait_en_s;
  logic       wait_clear_s;
  logic       wait_expired_s;

  // A request completes only while it is actually being driven; a stray
  // mem_ready with mem_req low (e.g. the cycle after reset) is ignored.
  assign accept_s     = mem_req_q && mem_ready;
  assign wait_en_s    = mem_req_q && !mem_ready &&
                        ((state_q == ST_FETCH) || (state_q == ST_MEMW));
  assign wait_clear_s = (state_d != state_q);

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear_s),
    .en      (wait_en_s),
    .expired (wait_expired_s)
  );

  // Next-state logic; registered outputs are derived from the next state so
  // each strobe is high exactly for the cycle its state is occupied.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    reg_wsrc_d = reg_wsrc_q;
    fault_d    = fault_q;

    case (state_q)
      ST_FETCH: begin
        if (accept_s) begin
          instr_d = mem_rdata;
          state_d = ST_DECODE;
        end else if (wait_expired_s) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_alu(instr_q)) begin
          state_d = ST_EXEC;
        end else begin
          case (instr_q[7:4])
            OP_LD:    state_d = ST_MEMW;
            OP_ST:    state_d = ST_MEMW;
            OP_MOV16: state_d = ST_EXEC;
            OP_HLT:   state_d = ST_HALT;
            default:  state_d = ST_FETCH;
          endcase
        end
      end
      ST_EXEC: begin
        if (is_alu(instr_q)) begin
          reg_wsrc_d = 1'b0;
          state_d    = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEMW: begin
        if (accept_s) begin
          // LD data is captured by the register-file side latch on this edge.
          if (instr_q[7:4] == OP_LD) begin
            reg_wsrc_d = 1'b1;
            state_d    = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (wait_expired_s) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_MEMW;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    mem_req_d  = (state_d == ST_FETCH) || (state_d == ST_MEMW);
    mem_we_d   = (state_d == ST_MEMW) && (instr_q[7:4] == OP_ST);
    alu_en_d   = (state_d == ST_EXEC) && is_alu(instr_q);
    reg16_we_d = (state_d == ST_EXEC) && !is_alu(instr_q);
    reg_we_d   = (state_d == ST_WB);
    halted_d   = (state_d == ST_HALT);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      instr_q    <= 8'h00;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      alu_en_q   <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_wsrc_q <= 1'b0;
      reg16_we_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      alu_en_q   <= alu_en_d;
      reg_we_q   <= reg_we_d;
      reg_wsrc_q <= reg_wsrc_d;
      reg16_we_q <= reg16_we_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // pc_inc must land in the accepting fetch cycle, which is only known from
  // mem_ready in that same cycle, so it is decoded from flops plus mem_ready.
  assign pc_inc    = (state_q == ST_FETCH) && accept_s;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign instr     = instr_q;
  assign alu_op    = instr_q[6:4];
  assign alu_shamt = instr_q[2:0];
  assign alu_en    = alu_en_q;
  assign reg_sel   = instr_q[3:0];
  assign reg_we    = reg_we_q;
  assign reg_wsrc  = reg_wsrc_q;
  assign reg16_src = instr_q[3:2];
  assign reg16_dst = instr_q[1:0];
  assign reg16_we  = reg16_we_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_instr_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_seq
// Directed bench for instr_seq (WAIT_MAX = 4). Inputs change 1 time unit after
// the rising edge; outputs are checked 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_instr_seq;

  logic       clk;
  logic       rst;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       pc_inc;
  logic [7:0] instr;
  logic [2:0] alu_op;
  logic [2:0] alu_shamt;
  logic       alu_en;
  logic [3:0] reg_sel;
  logic       reg_we;
  logic       reg_wsrc;
  logic [1:0] reg16_src;
  logic [1:0] reg16_dst;
  logic       reg16_we;
  logic       halted;
  logic       fault;

  int checks;
  int errors;

  instr_seq #(
    .WAIT_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .pc_inc    (pc_inc),
    .instr     (instr),
    .alu_op    (alu_op),
    .alu_shamt (alu_shamt),
    .alu_en    (alu_en),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_wsrc  (reg_wsrc),
    .reg16_src (reg16_src),
    .reg16_dst (reg16_dst),
    .reg16_we  (reg16_we),
    .halted    (halted),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values, and mem_ready ignored while mem_req is low.
  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = 8'h00;
    step();
    mem_ready = 1'b1; mem_rdata = 8'hFF;
    #1;
    checks++; if ({mem_req, mem_we, pc_inc, alu_en, reg_we, reg16_we} !== 6'b000000) begin errors++; $display("FAIL rst_strobes: got %b expected 000000", {mem_req, mem_we, pc_inc, alu_en, reg_we, reg16_we}); end
    checks++; if ({halted, fault, reg_wsrc} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {halted, fault, reg_wsrc}); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL rst_instr: got %h expected 00", instr); end
    rst = 1'b0;
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_first_fetch_req: got %b expected 1", mem_req); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL rst_ignored_ready: got %h expected 00", instr); end
  endtask

  // ALU 8'h35 with zero-wait fetch: 4 cycles.
  task automatic test_alu();
    mem_rdata = 8'h35; mem_ready = 1'b1;
    #1;
    checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL alu_pc_inc: got %b expected 1", pc_inc); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({mem_req, pc_inc, alu_en, reg_we} !== 4'b0000) begin errors++; $display("FAIL alu_decode_quiet: got %b expected 0000", {mem_req, pc_inc, alu_en, reg_we}); end
    checks++; if (instr !== 8'h35) begin errors++; $display("FAIL alu_instr: got %h expected 35", instr); end
    step();
    checks++; if ({alu_en, reg_we, alu_op, alu_shamt} !== {1'b1, 1'b0, 3'd3, 3'd5}) begin errors++; $display("FAIL alu_exec: got en=%b we=%b op=%0d sh=%0d expected en=1 we=0 op=3 sh=5", alu_en, reg_we, alu_op, alu_shamt); end
    step();
    checks++; if ({reg_we, alu_en, reg_wsrc, reg_sel} !== {1'b1, 1'b0, 1'b0, 4'd5}) begin errors++; $display("FAIL alu_wb: got we=%b en=%b src=%b sel=%0d expected we=1 en=0 src=0 sel=5", reg_we, alu_en, reg_wsrc, reg_sel); end
    step();
    checks++; if ({mem_req, reg_we} !== 2'b10) begin errors++; $display("FAIL alu_next_fetch: got req=%b we=%b expected req=1 we=0", mem_req, reg_we); end
  endtask

  // LD 8'h82, ready delayed 3 cycles in MEMW (one below WAIT_MAX): 7 cycles.
  task automatic test_ld_wait();
    mem_rdata = 8'h82; mem_ready = 1'b1;
    #1;
    checks++; if (pc_inc !== 1'b1) begin errors++; $display("FAIL ld_pc_inc: got %b expected 1", pc_inc); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({mem_req, reg_sel} !== {1'b0, 4'd2}) begin errors++; $display("FAIL ld_decode: got req=%b sel=%0d expected req=0 sel=2", mem_req, reg_sel); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({mem_req, mem_we, fault, reg_we} !== 4'b1000) begin errors++; $display("FAIL ld_memw_wait%0d: got req/we/fault/rwe=%b expected 1000", i, {mem_req, mem_we, fault, reg_we}); end
    end
    step();
    mem_ready = 1'b1; mem_rdata = 8'h5A;
    #1;
    checks++; if ({mem_req, mem_we, pc_inc, fault} !== 4'b1000) begin errors++; $display("FAIL ld_memw_accept: got %b expected 1000", {mem_req, mem_we, pc_inc, fault}); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({reg_we, reg_wsrc, reg_sel, mem_req} !== {1'b1, 1'b1, 4'd2, 1'b0}) begin errors++; $display("FAIL ld_wb: got we=%b src=%b sel=%0d req=%b expected we=1 src=1 sel=2 req=0", reg_we, reg_wsrc, reg_sel, mem_req); end
    checks++; if (instr !== 8'h82) begin errors++; $display("FAIL ld_instr_kept: got %h expected 82", instr); end
    step();
    checks++; if ({mem_req, reg_we} !== 2'b10) begin errors++; $display("FAIL ld_next_fetch: got req=%b we=%b expected req=1 we=0", mem_req, reg_we); end
  endtask

  // ST 8'h94 (3 cycles) followed by MOV16 8'hA6 (3 cycles).
  task automatic test_st_mov16();
    mem_rdata = 8'h94; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1; mem_rdata = 8'h00;
    #1;
    checks++; if ({mem_req, mem_we, reg_we} !== 3'b110) begin errors++; $display("FAIL st_memw: got req/we/rwe=%b expected 110", {mem_req, mem_we, reg_we}); end
    step();
    mem_rdata = 8'hA6; mem_ready = 1'b1;
    #1;
    checks++; if ({mem_req, mem_we, reg_we, pc_inc} !== 4'b1001) begin errors++; $display("FAIL st_then_fetch: got req/we/rwe/pc=%b expected 1001", {mem_req, mem_we, reg_we, pc_inc}); end
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({reg16_src, reg16_dst, reg16_we} !== {2'd1, 2'd2, 1'b0}) begin errors++; $display("FAIL mov_decode: got src=%0d dst=%0d we=%b expected src=1 dst=2 we=0", reg16_src, reg16_dst, reg16_we); end
    step();
    checks++; if ({reg16_we, alu_en, reg_we, mem_req} !== 4'b1000) begin errors++; $display("FAIL mov_exec: got %b expected 1000", {reg16_we, alu_en, reg_we, mem_req}); end
    step();
    checks++; if ({reg16_we, mem_req, reg_we} !== 3'b010) begin errors++; $display("FAIL mov_next_fetch: got %b expected 010", {reg16_we, mem_req, reg_we}); end
  endtask

  // NOP 8'hC3: 2 cycles.
  task automatic test_nop();
    mem_rdata = 8'hC3; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    #1;
    checks++; if ({mem_req, alu_en, reg_we, reg16_we} !== 4'b0000) begin errors++; $display("FAIL nop_decode: got %b expected 0000", {mem_req, alu_en, reg_we, reg16_we}); end
    step();
    checks++; if ({mem_req, alu_en, reg_we, reg16_we} !== 4'b1000) begin errors++; $display("FAIL nop_next_fetch: got %b expected 1000", {mem_req, alu_en, reg_we, reg16_we}); end
  endtask

  // Fetch timeout after WAIT_MAX=4 wait cycles; instr keeps 8'hC3.
  task automatic test_fault();
    mem_ready = 1'b0; mem_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({mem_req, fault, halted} !== 3'b100) begin errors++; $display("FAIL fault_wait%0d: got req/fault/halt=%b expected 100", i, {mem_req, fault, halted}); end
      step();
    end
    checks++; if ({fault, halted, mem_req} !== 3'b110) begin errors++; $display("FAIL fault_raised: got fault/halt/req=%b expected 110", {fault, halted, mem_req}); end
    checks++; if (instr !== 8'hC3) begin errors++; $display("FAIL fault_instr: got %h expected c3", instr); end
    mem_ready = 1'b1;
    step();
    step();
    checks++; if ({fault, halted, mem_req, pc_inc, instr} !== {4'b1100, 8'hC3}) begin errors++; $display("FAIL fault_sticky: got %b instr %h expected 1100 c3", {fault, halted, mem_req, pc_inc}, instr); end
    rst = 1'b1; mem_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++; if ({fault, halted, mem_req} !== 3'b001) begin errors++; $display("FAIL fault_rst_exit: got %b expected 001", {fault, halted, mem_req}); end
  endtask

  // HLT 8'hF0 holds for 20 cycles despite mem_ready activity; rst exits.
  task automatic test_hlt();
    mem_rdata = 8'hF0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      checks++; if ({halted, fault, mem_req, pc_inc, alu_en, reg_we, reg16_we} !== 7'b1000000) begin errors++; $display("FAIL hlt_hold%0d: got %b expected 1000000", i, {halted, fault, mem_req, pc_inc, alu_en, reg_we, reg16_we}); end
      step();
    end
    rst = 1'b1; mem_ready = 1'b0;
    step();
    checks++; if ({halted, mem_req} !== 2'b00) begin errors++; $display("FAIL hlt_rst_cycle: got %b expected 00", {halted, mem_req}); end
    rst = 1'b0;
    step();
    checks++; if ({halted, mem_req} !== 2'b01) begin errors++; $display("FAIL hlt_refetch: got %b expected 01", {halted, mem_req}); end
  endtask

  // rst in EXEC of ALU 8'h35 aborts it; then ALU 8'h12 runs cleanly.
  task automatic test_reset_mid_exec();
    mem_rdata = 8'h35; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL abort_in_exec: got %b expected 1", alu_en); end
    rst = 1'b1;
    step();
    checks++; if ({mem_req, mem_we, pc_inc, alu_en, reg_we, reg16_we, halted, fault, reg_wsrc} !== 9'b0) begin errors++; $display("FAIL abort_outputs: got %b expected 000000000", {mem_req, mem_we, pc_inc, alu_en, reg_we, reg16_we, halted, fault, reg_wsrc}); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL abort_instr: got %h expected 00", instr); end
    rst = 1'b0;
    step();
    mem_rdata = 8'h12; mem_ready = 1'b1;
    #1;
    checks++; if ({mem_req, reg_we, pc_inc} !== 3'b101) begin errors++; $display("FAIL abort_refetch: got %b expected 101", {mem_req, reg_we, pc_inc}); end
    step();
    mem_ready = 1'b0;
    step();
    checks++; if ({alu_en, alu_op, alu_shamt} !== {1'b1, 3'd1, 3'd2}) begin errors++; $display("FAIL abort_next_exec: got en=%b op=%0d sh=%0d expected en=1 op=1 sh=2", alu_en, alu_op, alu_shamt); end
    step();
    checks++; if ({reg_we, reg_sel, reg_wsrc} !== {1'b1, 4'd2, 1'b0}) begin errors++; $display("FAIL abort_next_wb: got we=%b sel=%0d src=%b expected we=1 sel=2 src=0", reg_we, reg_sel, reg_wsrc); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    test_reset();
    test_alu();
    test_ld_wait();
    test_st_mov16();
    test_nop();
    test_fault();
    test_hlt();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
